// File: rtl/e203_fpu_regfile_mp_pkg.sv
// Shared constants and helpers for the multi-port FP register file and its scoreboard.
package e203_fpu_regfile_mp_pkg;

   // Default register width (F+D) and register count of the FPU register file
   localparam int E203_FLEN          = 64;
   localparam int E203_FPU_RFREG_NUM = 32;

   // Width of a single-precision value inside a wider register
   localparam int SP_W = 32;

   // A single-precision result needs NaN-boxing only when the register is wider than SP
   function automatic logic nan_box_en(input int flen, input logic sp);
      return (flen > SP_W) && sp;
   endfunction

endpackage

// File: rtl/e203_fpu_sboard.sv
// FP register scoreboard: one pending bit per register plus a registered count of
// pending registers. Priority per register: flush, then new issue, then retire, else hold.
module e203_fpu_sboard
   import e203_fpu_regfile_mp_pkg::*;
#(
   parameter  int NREG = E203_FPU_RFREG_NUM,
   parameter  int NWR  = 2,
   localparam int IDXW = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*IDXW-1:0] wr_idx,
   input  logic [NWR-1:0]      wr_clr,
   input  logic                iss_vld,
   input  logic [IDXW-1:0]     iss_idx,
   input  logic                flush,
   output logic [NREG-1:0]     pend,
   output logic [IDXW:0]       busy_cnt
);

   logic [NREG-1:0] pend_r;
   logic [NREG-1:0] pend_nxt_s;
   logic [IDXW:0]   cnt_r;
   logic [IDXW:0]   cnt_nxt_s;

   // Next pending vector: a new producer beats a same-cycle retire of the older one
   always_comb begin : p_pend_nxt
      logic clr_s;
      pend_nxt_s = pend_r;
      clr_s      = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         clr_s = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            clr_s = clr_s | (wr_en[p] & wr_clr[p] &
                             (wr_idx[p*IDXW +: IDXW] == IDXW'(r)));
         end
         if (flush) begin
            pend_nxt_s[r] = 1'b0;
         end else if (iss_vld && (iss_idx == IDXW'(r))) begin
            pend_nxt_s[r] = 1'b1;
         end else if (clr_s) begin
            pend_nxt_s[r] = 1'b0;
         end else begin
            pend_nxt_s[r] = pend_r[r];
         end
      end
   end

   // Population count of the next pending vector, so the count tracks the bits exactly
   always_comb begin : p_cnt_nxt
      cnt_nxt_s = '0;
      for (int r = 0; r < NREG; r++) begin
         cnt_nxt_s = cnt_nxt_s + (IDXW+1)'(pend_nxt_s[r]);
      end
   end

   // Pending bits and busy count registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r <= '0;
         cnt_r  <= '0;
      end else begin
         pend_r <= pend_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   assign pend     = pend_r;
   assign busy_cnt = cnt_r;

endmodule

// File: rtl/e203_fpu_regfile_mp.sv
// Multi-port FP register file: NRD combinational read ports, NWR write ports
// (higher port index wins on a same-index collision), optional write-to-read bypass,
// NaN-boxing of single-precision results and an integrated RAW scoreboard.
module e203_fpu_regfile_mp
   import e203_fpu_regfile_mp_pkg::*;
#(
   parameter  int FLEN   = E203_FLEN,
   parameter  int NREG   = E203_FPU_RFREG_NUM,
   parameter  int NRD    = 3,
   parameter  int NWR    = 2,
   parameter  int BYPASS = 1,
   localparam int IDXW   = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*IDXW-1:0] rd_idx,
   output logic [NRD*FLEN-1:0] rd_dat,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*IDXW-1:0] wr_idx,
   input  logic [NWR*FLEN-1:0] wr_dat,
   input  logic [NWR-1:0]      wr_sp,
   input  logic [NWR-1:0]      wr_clr,
   input  logic                iss_vld,
   input  logic [IDXW-1:0]     iss_idx,
   input  logic                flush,
   output logic [IDXW:0]       busy_cnt
);

   logic [FLEN-1:0] box_s [NWR];
   logic [FLEN-1:0] rf_s  [NREG];
   logic [NREG-1:0] pend_s;

   // Per write port: the value as it will be stored (NaN-boxed when single precision)
   for (genvar p = 0; p < NWR; p++) begin : g_box
      if (FLEN > SP_W) begin : g_wide
         assign box_s[p] = nan_box_en(FLEN, wr_sp[p])
                         ? {{(FLEN-SP_W){1'b1}}, wr_dat[p*FLEN +: SP_W]}
                         : wr_dat[p*FLEN +: FLEN];
      end else begin : g_narrow
         assign box_s[p] = wr_dat[p*FLEN +: FLEN];
      end
   end

   // Data array: one enabled DFF row per register; out-of-range indices never match
   for (genvar r = 0; r < NREG; r++) begin : g_reg
      logic            we_s;
      logic [FLEN-1:0] wd_s;
      logic [FLEN-1:0] data_r;

      // Select the winning write for this register; later ports override earlier ones
      always_comb begin : p_wsel
         logic hit_s;
         we_s  = 1'b0;
         wd_s  = '0;
         hit_s = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            hit_s = wr_en[p] & (wr_idx[p*IDXW +: IDXW] == IDXW'(r));
            we_s  = we_s | hit_s;
            wd_s  = hit_s ? box_s[p] : wd_s;
         end
      end

      // Register storage row with async clear
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            data_r <= '0;
         end else if (we_s) begin
            data_r <= wd_s;
         end
      end

      assign rf_s[r] = data_r;
   end

   // Read ports: array value, optionally overridden by a same-cycle write
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [IDXW-1:0] idx_s;
      logic            in_rng_s;
      logic [FLEN-1:0] dat_s;

      assign idx_s    = rd_idx[k*IDXW +: IDXW];
      assign in_rng_s = ({1'b0, idx_s} < (IDXW+1)'(NREG));

      // Bypass mux: highest-index enabled write to the same register wins
      always_comb begin : p_byp
         logic hit_s;
         dat_s = in_rng_s ? rf_s[idx_s] : '0;
         hit_s = 1'b0;
         for (int p = 0; p < NWR; p++) begin
            hit_s = (BYPASS != 0) && in_rng_s && wr_en[p] &&
                    (wr_idx[p*IDXW +: IDXW] == idx_s);
            dat_s = hit_s ? box_s[p] : dat_s;
         end
      end

      assign rd_dat[k*FLEN +: FLEN] = dat_s;
      // Busy reflects the registered pending bit only; a same-cycle retire is not forwarded
      assign rd_busy[k] = in_rng_s ? pend_s[idx_s] : 1'b0;
   end

   e203_fpu_sboard #(
      .NREG (NREG),
      .NWR  (NWR)
   ) u_sboard (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_idx   (wr_idx),
      .wr_clr   (wr_clr),
      .iss_vld  (iss_vld),
      .iss_idx  (iss_idx),
      .flush    (flush),
      .pend     (pend_s),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_e203_fpu_regfile_mp.sv
// Directed bench for the FP register file: a bypassing instance, a non-bypassing
// instance and a 24-entry instance share all inputs; expected values are hand-computed.
module tb_e203_fpu_regfile_mp;

   localparam int FLEN = 64;
   localparam int NRD  = 3;
   localparam int NWR  = 2;
   localparam int IDXW = 5;

   logic                clk = 1'b0;
   logic                rst;
   logic [NRD*IDXW-1:0] rd_idx;
   logic [NWR-1:0]      wr_en;
   logic [NWR*IDXW-1:0] wr_idx;
   logic [NWR*FLEN-1:0] wr_dat;
   logic [NWR-1:0]      wr_sp;
   logic [NWR-1:0]      wr_clr;
   logic                iss_vld;
   logic [IDXW-1:0]     iss_idx;
   logic                flush;

   logic [NRD*FLEN-1:0] rd_dat_b,  rd_dat_n,  rd_dat_p;
   logic [NRD-1:0]      rd_busy_b, rd_busy_n, rd_busy_p;
   logic [IDXW:0]       cnt_b,     cnt_n,     cnt_p;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   e203_fpu_regfile_mp #(.FLEN(64), .NREG(32), .NRD(3), .NWR(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_dat(wr_dat), .wr_sp(wr_sp), .wr_clr(wr_clr),
      .iss_vld(iss_vld), .iss_idx(iss_idx), .flush(flush), .busy_cnt(cnt_b));

   e203_fpu_regfile_mp #(.FLEN(64), .NREG(32), .NRD(3), .NWR(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_dat(wr_dat), .wr_sp(wr_sp), .wr_clr(wr_clr),
      .iss_vld(iss_vld), .iss_idx(iss_idx), .flush(flush), .busy_cnt(cnt_n));

   e203_fpu_regfile_mp #(.FLEN(64), .NREG(24), .NRD(3), .NWR(2), .BYPASS(1)) dut_np (
      .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_dat(rd_dat_p), .rd_busy(rd_busy_p),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_dat(wr_dat), .wr_sp(wr_sp), .wr_clr(wr_clr),
      .iss_vld(iss_vld), .iss_idx(iss_idx), .flush(flush), .busy_cnt(cnt_p));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] db(input int k);
      return rd_dat_b[k*FLEN +: FLEN];
   endfunction

   function automatic logic [63:0] dn(input int k);
      return rd_dat_n[k*FLEN +: FLEN];
   endfunction

   function automatic logic [63:0] dp(input int k);
      return rd_dat_p[k*FLEN +: FLEN];
   endfunction

   task automatic idle();
      wr_en   = '0;
      wr_idx  = '0;
      wr_dat  = '0;
      wr_sp   = '0;
      wr_clr  = '0;
      iss_vld = 1'b0;
      iss_idx = '0;
      flush   = 1'b0;
   endtask

   task automatic wr(input int p, input logic [4:0] idx, input logic [63:0] d,
                     input logic sp, input logic clr);
      wr_en[p]                 = 1'b1;
      wr_idx[p*IDXW +: IDXW]   = idx;
      wr_dat[p*FLEN +: FLEN]   = d;
      wr_sp[p]                 = sp;
      wr_clr[p]                = clr;
   endtask

   task automatic rd(input int k, input logic [4:0] idx);
      rd_idx[k*IDXW +: IDXW] = idx;
   endtask

   task automatic iss(input logic [4:0] idx);
      iss_vld = 1'b1;
      iss_idx = idx;
   endtask

   // Clock the current inputs in, then return to idle and let outputs settle
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst    = 1'b1;
      rd_idx = '0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset_dat", db(0), 64'h0);
      check("reset_busy", 64'(rd_busy_b), 64'h0);
      check("reset_cnt", 64'(cnt_b), 64'h0);
      rst = 1'b0;
      #1;

      // SP write is NaN-boxed; bypass sees it the same cycle, non-bypass sees old value
      wr(0, 5'd5, 64'h0000_0000_3F80_0000, 1'b1, 1'b0);
      rd(0, 5'd5);
      #1;
      check("sp_byp", db(0), 64'hFFFF_FFFF_3F80_0000);
      check("sp_nobyp_old", dn(0), 64'h0);
      tick();
      check("sp_stored", db(0), 64'hFFFF_FFFF_3F80_0000);
      check("sp_stored_nb", dn(0), 64'hFFFF_FFFF_3F80_0000);

      // Same-index collision: port 1 wins
      wr(0, 5'd3, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
      wr(1, 5'd3, 64'h2222_2222_2222_2222, 1'b0, 1'b0);
      rd(1, 5'd3);
      #1;
      check("coll_byp", db(1), 64'h2222_2222_2222_2222);
      check("coll_nobyp_old", dn(1), 64'h0);
      tick();
      check("coll_stored", db(1), 64'h2222_2222_2222_2222);
      check("coll_stored_nb", dn(1), 64'h2222_2222_2222_2222);

      // Scoreboard: issue f7, then re-issue with same-cycle retire, then retire alone
      iss(5'd7);
      rd(2, 5'd7);
      #1;
      check("iss_busy_not_yet", 64'(rd_busy_b[2]), 64'h0);
      tick();
      check("iss_busy", 64'(rd_busy_b[2]), 64'h1);
      check("iss_cnt", 64'(cnt_b), 64'h1);
      iss(5'd7);
      wr(0, 5'd7, 64'h5, 1'b0, 1'b1);
      tick();
      check("waw_busy", 64'(rd_busy_b[2]), 64'h1);
      check("waw_cnt", 64'(cnt_b), 64'h1);
      wr(1, 5'd7, 64'h6, 1'b0, 1'b1);
      #1;
      check("clr_not_fwd", 64'(rd_busy_b[2]), 64'h1);
      tick();
      check("clr_busy", 64'(rd_busy_b[2]), 64'h0);
      check("clr_cnt", 64'(cnt_b), 64'h0);
      check("clr_data", db(2), 64'h6);

      // Collision where only the losing port retires: pending still cleared
      iss(5'd3);
      tick();
      check("coll_iss_cnt", 64'(cnt_b), 64'h1);
      wr(0, 5'd3, 64'h3333_3333_3333_3333, 1'b0, 1'b1);
      wr(1, 5'd3, 64'h4444_4444_4444_4444, 1'b0, 1'b0);
      tick();
      check("coll_clr_busy", 64'(rd_busy_b[1]), 64'h0);
      check("coll_clr_cnt", 64'(cnt_b), 64'h0);
      check("coll_clr_data", db(1), 64'h4444_4444_4444_4444);

      // Flush: four pending, flush beats a concurrent issue, concurrent write still lands
      for (int i = 10; i < 14; i++) begin
         iss(5'(i));
         tick();
      end
      check("flush_pre_cnt", 64'(cnt_b), 64'h4);
      check("flush_pre_cnt_np", 64'(cnt_p), 64'h4);
      flush = 1'b1;
      iss(5'd9);
      wr(1, 5'd2, 64'h55, 1'b0, 1'b0);
      rd(0, 5'd9);
      rd(1, 5'd2);
      tick();
      check("flush_cnt", 64'(cnt_b), 64'h0);
      check("flush_cnt_np", 64'(cnt_p), 64'h0);
      check("flush_busy_f9", 64'(rd_busy_b[0]), 64'h0);
      check("flush_write", db(1), 64'h55);
      check("flush_write_nb", dn(1), 64'h55);

      // No bypass: old value during the write cycle, new value afterwards
      wr(0, 5'd1, 64'hAB, 1'b0, 1'b0);
      rd(2, 5'd1);
      #1;
      check("nb_old", dn(2), 64'h0);
      check("b_new", db(2), 64'hAB);
      tick();
      check("nb_new", dn(2), 64'hAB);

      // 24-entry file: index 25 ignored for write, read and scoreboard
      wr(0, 5'd25, 64'h77, 1'b0, 1'b0);
      wr(1, 5'd20, 64'h99, 1'b0, 1'b0);
      iss(5'd25);
      rd(0, 5'd25);
      rd(1, 5'd20);
      #1;
      check("np_oor_byp", dp(0), 64'h0);
      tick();
      check("np_oor_dat", dp(0), 64'h0);
      check("np_oor_busy", 64'(rd_busy_p[0]), 64'h0);
      check("np_oor_cnt", 64'(cnt_p), 64'h0);
      check("np_in_rng", dp(1), 64'h99);
      check("full_f25_dat", db(0), 64'h77);
      check("full_f25_cnt", 64'(cnt_b), 64'h1);

      // Asynchronous reset mid-cycle clears data and pending without a clock edge
      #3;
      rst = 1'b1;
      #1;
      for (int k = 0; k < NRD; k++) begin
         check($sformatf("arst_dat%0d", k), db(k), 64'h0);
         check($sformatf("arst_dat_nb%0d", k), dn(k), 64'h0);
      end
      check("arst_busy", 64'(rd_busy_b), 64'h0);
      check("arst_cnt", 64'(cnt_b), 64'h0);
      @(posedge clk);
      #1;
      check("arst_held_cnt", 64'(cnt_b), 64'h0);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
